// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   state_t : FSM encoding (RUN = 2'b00, MC_WAIT = 2'b01)
//   REG_ZERO: architectural zero register index (never a hazard source)
//   STATS_W : width of the optional statistics counters
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MC_WAIT = 2'b01
  } state_t;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned STATS_W  = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master: pipeline side, drives hazard sources, receives stage controls.
//   slave : controller side, samples hazard sources, drives stage controls.
// Hazard sources : idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
//                  ifid_uses_rt_i, branch_taken_i, mc_start_i
// Stage controls : pc_write_o, ifid_write_o, idex_write_o,
//                  ifid_flush_o, idex_flush_o, exmem_flush_o
// Statistics     : stall_cycles_o, flush_count_o (zero unless HAZARD_STATS_EN)
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
);
  logic              idex_memread_i;
  logic [REG_AW-1:0] idex_rt_i;
  logic [REG_AW-1:0] ifid_rs_i;
  logic [REG_AW-1:0] ifid_rt_i;
  logic              ifid_uses_rt_i;
  logic              branch_taken_i;
  logic              mc_start_i;
  logic              pc_write_o;
  logic              ifid_write_o;
  logic              idex_write_o;
  logic              ifid_flush_o;
  logic              idex_flush_o;
  logic              exmem_flush_o;
  logic [STATS_W-1:0] stall_cycles_o;
  logic [STATS_W-1:0] flush_count_o;

  modport master (
    output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           branch_taken_i, mc_start_i,
    input  pc_write_o, ifid_write_o, idex_write_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o,
           stall_cycles_o, flush_count_o
  );

  modport slave (
    input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           branch_taken_i, mc_start_i,
    output pc_write_o, ifid_write_o, idex_write_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o,
           stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector.
//   memread_i : instruction in EX is a load
//   ld_rd_i   : load destination register
//   rs_i/rt_i : source registers of the instruction in ID
//   uses_rt_i : ID instruction actually reads rt
//   lu_o      : ID instruction needs the load result next cycle
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              memread_i,
  input  logic [REG_AW-1:0] ld_rd_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              uses_rt_i,
  output logic              lu_o
);
  always_comb begin
    lu_o = memread_i && (ld_rd_i != REG_AW'(REG_ZERO)) &&
           ((ld_rd_i == rs_i) || (uses_rt_i && (ld_rd_i == rt_i)));
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// multi-cycle EX freezes. Sole source of the PC write enable.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   hz    : pipe_hazard_ctrl_if.slave (hazard sources in, stage controls out)
// Optional: HAZARD_STATS_EN adds saturating stall-cycle / branch-flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_hazard_ctrl_if.slave  hz
);
  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             lu;
  logic             br_acc;

  load_use_detect #(.REG_AW(REG_AW)) u_lu (
    .memread_i (hz.idex_memread_i),
    .ld_rd_i   (hz.idex_rt_i),
    .rs_i      (hz.ifid_rs_i),
    .rt_i      (hz.ifid_rt_i),
    .uses_rt_i (hz.ifid_uses_rt_i),
    .lu_o      (lu)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    case (state_q)
      RUN: begin
        // A taken branch squashes a multi-cycle op starting in the same cycle.
        if (hz.mc_start_i && !hz.branch_taken_i) begin
          state_nx = MC_WAIT;
          cnt_nx   = CNT_W'(MC_LAT - 1);
        end
      end
      MC_WAIT: begin
        cnt_nx = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_nx = RUN;
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    hz.pc_write_o    = 1'b0;
    hz.ifid_write_o  = 1'b0;
    hz.idex_write_o  = 1'b0;
    hz.ifid_flush_o  = 1'b0;
    hz.idex_flush_o  = 1'b0;
    hz.exmem_flush_o = 1'b0;
    br_acc           = 1'b0;
    if (rst_i) begin
      case (state_q)
        RUN: begin
          if (hz.branch_taken_i) begin
            br_acc           = 1'b1;
            hz.pc_write_o    = 1'b1;
            hz.ifid_write_o  = 1'b1;
            hz.idex_write_o  = 1'b1;
            hz.ifid_flush_o  = 1'b1;
            hz.idex_flush_o  = 1'b1;
            hz.exmem_flush_o = 1'b1;
          end else if (hz.mc_start_i) begin
            hz.exmem_flush_o = 1'b1;
          end else if (lu) begin
            hz.idex_write_o  = 1'b1;
            hz.idex_flush_o  = 1'b1;
          end else begin
            hz.pc_write_o    = 1'b1;
            hz.ifid_write_o  = 1'b1;
            hz.idex_write_o  = 1'b1;
          end
        end
        MC_WAIT: begin
          hz.exmem_flush_o = 1'b1;
        end
        default: begin
          hz.pc_write_o    = 1'b1;
          hz.ifid_write_o  = 1'b1;
          hz.idex_write_o  = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STATS_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!hz.pc_write_o && (stall_q != '1)) stall_q <= stall_q + STATS_W'(1);
      if (br_acc && (flush_q != '1))         flush_q <= flush_q + STATS_W'(1);
    end
  end

  assign hz.stall_cycles_o = stall_q;
  assign hz.flush_count_o  = flush_q;
`else
  assign hz.stall_cycles_o = '0;
  assign hz.flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  typedef struct {
    string       name;
    logic [5:0]  ctl;      // {pc_w, ifid_w, idex_w, ifid_fl, idex_fl, exmem_fl}
    bit          chk_st;
    int unsigned stall;
    int unsigned flush;
  } exp_t;

  localparam logic [5:0] E_RST = 6'b000_000;
  localparam logic [5:0] E_RUN = 6'b111_000;
  localparam logic [5:0] E_LU  = 6'b001_010;
  localparam logic [5:0] E_BR  = 6'b111_111;
  localparam logic [5:0] E_FRZ = 6'b000_001;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5)) hz_if ();

  pipe_hazard_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(3)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .hz    (hz_if.slave)
  );

  task automatic step(input logic rst, input logic mr, input logic [4:0] irt,
                      input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                      input logic br, input logic mc, input logic [5:0] e,
                      input string nm, input bit cs = 1'b0,
                      input int unsigned st = 0, input int unsigned fl = 0);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n                      = rst;
    hz_if.idex_memread_i       = mr;
    hz_if.idex_rt_i            = irt;
    hz_if.ifid_rs_i            = rs;
    hz_if.ifid_rt_i            = rt;
    hz_if.ifid_uses_rt_i       = ur;
    hz_if.branch_taken_i       = br;
    hz_if.mc_start_i           = mc;
    x.name = nm; x.ctl = e; x.chk_st = cs; x.stall = st; x.flush = fl;
    q.push_back(x);
  endtask

  task automatic idle(input logic [5:0] e, input string nm);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, e, nm);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [5:0] act;
      x = q.pop_front();
      act = {hz_if.pc_write_o, hz_if.ifid_write_o, hz_if.idex_write_o,
             hz_if.ifid_flush_o, hz_if.idex_flush_o, hz_if.exmem_flush_o};
      checks++;
      if (act !== x.ctl) begin
        errors++;
        $display("FAIL %s: ctl got %b want %b", x.name, act, x.ctl);
      end
      if (x.chk_st) begin
        int unsigned ws, wf;
`ifdef HAZARD_STATS_EN
        ws = x.stall; wf = x.flush;
`else
        ws = 0; wf = 0;
`endif
        checks++;
        if (hz_if.stall_cycles_o !== ws) begin
          errors++;
          $display("FAIL %s: stall_cycles got %0d want %0d", x.name, hz_if.stall_cycles_o, ws);
        end
        checks++;
        if (hz_if.flush_count_o !== wf) begin
          errors++;
          $display("FAIL %s: flush_count got %0d want %0d", x.name, hz_if.flush_count_o, wf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d want 0", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    hz_if.idex_memread_i = 1'b0; hz_if.idex_rt_i = '0; hz_if.ifid_rs_i = '0;
    hz_if.ifid_rt_i = '0; hz_if.ifid_uses_rt_i = 1'b0;
    hz_if.branch_taken_i = 1'b0; hz_if.mc_start_i = 1'b0;

    // 1. reset held three cycles, then release
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, "reset_hold", 1'b1, 0, 0);
    idle(E_RUN, "reset_release");

    // 2. load-use cases
    step(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, E_LU,  "lu_rs");
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN, "lu_r0");
    step(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, E_LU,  "lu_rt");
    step(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, E_RUN, "lu_rt_unused");
    step(1'b1, 1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, E_RUN, "lu_no_load");

    // 3. multi-cycle op: 4 frozen cycles, br during wait ignored
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_FRZ, "mc_start");
    idle(E_FRZ, "mc_wait1");
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_FRZ, "mc_wait2_br");
    step(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, E_FRZ, "mc_wait3_lu");
    idle(E_RUN, "mc_done");

    // 4. br + mc_start: flush wins, stays RUN
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, E_BR, "br_mc");
    idle(E_RUN, "br_mc_next");

    // 5. mc_start + lu: freeze only
    step(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, E_FRZ, "mc_lu");
    for (int i = 0; i < 3; i++) idle(E_FRZ, "mc_lu_wait");
    idle(E_RUN, "mc_lu_done");

    // 6. reset during second wait cycle
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_FRZ, "rst_mc_start");
    idle(E_FRZ, "rst_mc_wait1");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, "rst_mid_wait");
    idle(E_RUN, "rst_mid_release");

    // 7. stats: clean reset, multi-cycle op, one branch
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, "st_reset", 1'b1, 0, 0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_FRZ, "st_mc");
    for (int i = 0; i < 3; i++) idle(E_FRZ, "st_wait");
    idle(E_RUN, "st_mc_done");
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_BR, "st_br");
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN, "st_final", 1'b1, 4, 1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: queue depth got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage pipelined CPU. It drives the program counter's write enable and the IF/ID, ID/EX and EX/MEM stage control signals. It resolves three events:
- load-use stalls;
- taken-branch flushes;
- multi-cycle EX operations, which freeze the front end.

It is the sole source of pc_write for the program counter register.

Parameters:
REG_AW, 5, register-address width.
MC_LAT, 4, total EX-occupancy cycles of a multi-cycle op; must be >= 2.
CNT_W, 3, width of the internal multi-cycle counter; must satisfy 2^CNT_W > MC_LAT.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous active-low reset.
idex_memread_i  input  1  instruction in EX is a load.
idex_rt_i  input  REG_AW  load destination register in EX.
ifid_rs_i  input  REG_AW  rs of instruction in ID.
ifid_rt_i  input  REG_AW  rt of instruction in ID.
ifid_uses_rt_i  input  1  ID instruction reads rt.
branch_taken_i  input  1  branch resolved taken in MEM.
mc_start_i  input  1  multi-cycle op is in its first EX cycle.
pc_write_o  output  1  program counter load enable.
ifid_write_o  output  1  IF/ID register load enable.
idex_write_o  output  1  ID/EX register load enable.
ifid_flush_o  output  1  clear IF/ID to NOP.
idex_flush_o  output  1  load a bubble into ID/EX.
exmem_flush_o  output  1  load a bubble into EX/MEM.
stall_cycles_o  output  32  stall-cycle count (optional feature).
flush_count_o  output  32  taken-branch flush count (optional feature).

Behaviour:
- Outputs are Mealy: combinational from state and current inputs. State and counter update on the rising edge of clk_i.
- Reset (rst_i low, asynchronous):
  - state returns to RUN, counter clears to 0;
  - all write enables and flushes are 0 while reset is held;
  - stats counters clear to 0.
  - Reset mid-MC_WAIT aborts the wait immediately.
- Default in RUN with no event: all three write enables = 1, all flushes = 0.
- Load-use hazard (lu) is asserted when all of the following hold:
  - idex_memread_i = 1;
  - idex_rt_i != 0;
  - idex_rt_i == ifid_rs_i, or (ifid_uses_rt_i = 1 and idex_rt_i == ifid_rt_i).
  - Response for that cycle only: pc_write = 0, ifid_write = 0, idex_flush = 1.
  - The bubble removes the condition on the next cycle, so no state is entered.
- Taken branch (br = branch_taken_i), in RUN:
  - ifid_flush = idex_flush = exmem_flush = 1;
  - pc_write = 1, so the external mux loads the target;
  - ifid_write = idex_write = 1.
- Multi-cycle op, mc_start_i in RUN without br:
  - that cycle: pc_write = ifid_write = idex_write = 0, exmem_flush = 1;
  - next state MC_WAIT, counter loaded with MC_LAT-1.
- MC_WAIT:
  - same freeze outputs as the mc_start cycle;
  - counter decrements each edge;
  - at an edge with counter == 1, next state is RUN;
  - total frozen cycles = MC_LAT.
  - lu, br and mc_start_i are ignored in MC_WAIT.
- Priority in RUN: br > mc_start > lu.
  - br together with mc_start: the flush wins, mc_start is ignored (the op is squashed) and the state stays RUN.
  - mc_start together with lu: freeze only, idex_flush = 0.
- States: RUN (2'b00), MC_WAIT (2'b01). Unreachable encodings return to RUN on the next edge, with default outputs.

Optional Feature:
HAZARD_STATS_EN defined:
- stall_cycles_o increments on every cycle where pc_write_o = 0 outside reset.
- flush_count_o increments on every accepted branch flush.
- Both counters saturate at 32'hFFFFFFFF.

HAZARD_STATS_EN undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package holds:
  - state encoding constants RUN and MC_WAIT;
  - REG_ZERO = 0;
  - STATS_W = 32.
- One sub-module, load_use_detect: purely combinational lu comparison, instantiated once.
- The FSM, counter and output mux remain in pipe_hazard_ctrl.

Test Plan:
1. Reset check: rst_i low for 3 cycles, then high with all inputs 0. Required: all outputs 0 during reset; first cycle after release gives pc_write = ifid_write = idex_write = 1 and all flushes 0.
2. Load-use: idex_memread = 1, idex_rt = 8, ifid_rs = 8 for one cycle. Required: pc_write = 0, ifid_write = 0, idex_flush = 1 that cycle. Then with idex_rt = 0 and rs = 0: no stall.
3. Multi-cycle with MC_LAT = 4: mc_start pulse. Required: pc_write = 0 for exactly 4 consecutive cycles, exmem_flush = 1 throughout, RUN outputs on the 5th cycle. A br pulse applied during the wait has no effect.
4. Same-cycle priority, part one: br and mc_start together. Required: three flushes = 1, pc_write = 1, next cycle in RUN.
5. Same-cycle priority, part two: mc_start and lu together. Required: freeze outputs and idex_flush = 0.
6. Reset on the 2nd MC_WAIT cycle. Required: state returns to RUN; after release pc_write = 1 immediately.
7. With HAZARD_STATS_EN, run scenario 3 plus one branch. Required: stall_cycles_o = 4, flush_count_o = 1.
